// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: shift-add MULTU and restoring DIVU.
// Results land in HI/LO on the edge that enters FIN and hold until the next completion.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t               state_r, state_nx;
  logic                 accept;
  logic                 last_iter;
  logic [CW-1:0]        cnt_r;
  logic [WIDTH-1:0]     opnd_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [2*WIDTH-1:0]   mul_acc;
  logic [2*WIDTH-1:0]   div_acc;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_rem;
  logic [WIDTH-1:0]     div_diff;
  logic                 div_ge;
  logic                 busy_r, done_r, dbz_r;
  logic [WIDTH-1:0]     hi_r, lo_r;

  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign HI          = hi_r;
  assign LO          = lo_r;

  // One iteration of each algorithm; the shifted remainder keeps its carry bit (W+1 wide).
  always_comb begin
    mul_sum  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
    if (acc_r[0]) begin
      mul_acc = {mul_sum, acc_r[WIDTH-1:1]};
    end else begin
      mul_acc = {1'b0, acc_r[2*WIDTH-1:1]};
    end
    div_rem  = acc_r[2*WIDTH-1:WIDTH-1];
    div_ge   = (div_rem >= {1'b0, opnd_r});
    div_diff = div_rem[WIDTH-1:0] - opnd_r;
    if (div_ge) begin
      div_acc = {div_diff, acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_acc = {acc_r[2*WIDTH-2:0], 1'b0};
    end
  end

  // Next-state logic and accept decode.
  always_comb begin
    state_nx  = state_r;
    accept    = 1'b0;
    last_iter = (cnt_r == LAST);
    case (state_r)
      IDLE, FIN: begin
        if (start) begin
          accept = 1'b1;
          if (!op) begin
            state_nx = MUL;
          end else if (B == {WIDTH{1'b0}}) begin
            state_nx = FIN;
          end else begin
            state_nx = DIV;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      MUL: begin
        if (last_iter) begin
          state_nx = FIN;
        end else begin
          state_nx = MUL;
        end
      end
      DIV: begin
        if (last_iter) begin
          state_nx = FIN;
        end else begin
          state_nx = DIV;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and result registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      opnd_r  <= {WIDTH{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nx;
      busy_r  <= (state_nx == MUL) || (state_nx == DIV);
      done_r  <= (state_nx == FIN);
      case (state_r)
        IDLE, FIN: begin
          if (accept) begin
            cnt_r  <= {CW{1'b0}};
            dbz_r  <= op && (B == {WIDTH{1'b0}});
            opnd_r <= op ? B : A;
            acc_r  <= {{WIDTH{1'b0}}, (op ? A : B)};
            if (op && (B == {WIDTH{1'b0}})) begin
              hi_r <= A;
              lo_r <= {WIDTH{1'b1}};
            end
          end
        end
        MUL: begin
          acc_r <= mul_acc;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (last_iter) begin
            hi_r <= mul_acc[2*WIDTH-1:WIDTH];
            lo_r <= mul_acc[WIDTH-1:0];
          end
        end
        DIV: begin
          acc_r <= div_acc;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (last_iter) begin
            hi_r <= div_acc[2*WIDTH-1:WIDTH];
            lo_r <= div_acc[WIDTH-1:0];
          end
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: latency, results, divide-by-zero,
// ignored start while busy, mid-operation reset and back-to-back issue.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op (optionally right in the current cycle for back-to-back), follow it to done.
  task automatic run_op(input string tag, input logic o, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input logic edbz, input bit b2b,
                        input bit poke);
    logic [W-1:0] prev_hi, prev_lo;
    int n, busy_cnt, elat;
    bit stable;
    if (!b2b) step();
    elat = (o && vb == '0) ? 1 : W + 1;
    start = 1'b1; op = o; a = va; b = vb;
    step();
    start = 1'b0;
    a = 32'h0BAD_0BAD; b = 32'h0000_0000;
    prev_hi = hi; prev_lo = lo;
    chk({tag, "_dbz_acc"}, {63'd0, div_by_zero}, {63'd0, edbz});
    n = 1; busy_cnt = 0; stable = 1'b1;
    while (!done && n < 100) begin
      if (busy) busy_cnt++;
      if (hi !== prev_hi || lo !== prev_lo) stable = 1'b0;
      if (poke && n == 5) begin
        start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      step();
      n++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 64'(n), 64'(elat));
    chk({tag, "_busy_cnt"}, 64'(busy_cnt), 64'(elat - 1));
    chk({tag, "_hold"}, {63'd0, stable}, 64'd1);
    chk({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, ehi});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, elo});
    chk({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, edbz});
  endtask

  initial begin
    int n;
    bit saw_done;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);

    run_op("mul7x6", 1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1'b0, 1'b0);
    run_op("mulmax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run_op("mulshf", 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 1'b0, 1'b0);
    run_op("div100", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 1'b0);
    run_op("div5_9", 1'b1, 32'd5, 32'd9, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
    run_op("divbig", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'd1, 1'b0, 1'b0, 1'b0);
    run_op("div0", 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op("mulclr", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0, 1'b0);
    run_op("poke", 1'b0, 32'd11, 32'd13, 32'd0, 32'd143, 1'b0, 1'b0, 1'b1);
    run_op("b2b", 1'b1, 32'd50, 32'd8, 32'd2, 32'd6, 1'b0, 1'b1, 1'b0);

    // Reset in the tenth busy cycle of a DIVU.
    step();
    start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd7;
    step();
    start = 1'b0;
    for (int i = 1; i < 10; i++) step();
    chk("mid_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_hilo", {hi, lo}, 64'd0);
    saw_done = 1'b0;
    for (n = 0; n < 40; n++) begin
      if (done) saw_done = 1'b1;
      step();
    end
    chk("mid_rst_nodone", {63'd0, saw_done}, 64'd0);
    run_op("fresh", 1'b0, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0, 1'b0, 1'b0);
    run_op("b2b_div0", 1'b1, 32'd77, 32'd0, 32'd77, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_op("b2b_mul", 1'b0, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
